cc_line_deserializer: RTL and testbench
=======================================

Name: cc_line_deserializer

Overview:
- Memory-side fill path of the cache controller; the inverse of the hit-data serializer.
- Collects an 8-beat wrapped AXI R burst (64-bit beats, critical word first) from MC into one 518-bit line word {byte_offset[5:0], data[511:0]} in natural word order.
- Hands the line to the cache data-array write / hit-data producer over a valid/ready interface.
- Sits on the mem R channel, in parallel with the reorder unit's tap of that channel.

Parameters:
- BEAT_W, 64, R-channel data width in bits.
- BEATS, 8, beats per cache line; must be a power of 2.
- OFF_W, 6, byte-offset field width; line word width = BEAT_W*BEATS + OFF_W = 518.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- req_valid_i  in  1  fill request pending (one per expected burst)
- req_offset_i  in  6  byte offset of the requested word; bits [5:3] give the start word
- req_ready_o  out  1  request accepted this cycle
- mem_rdata_i  in  64  R data beat
- mem_rlast_i  in  1  R last beat
- mem_rvalid_i  in  1  R valid
- mem_rready_o  out  1  R ready
- line_valid_o  out  1  assembled line valid
- line_data_o  out  518  {offset[5:0], word7..word0}; word k occupies [64k+63:64k]
- line_ready_i  in  1  consumer accepts line
- proto_err_o  out  1  one-cycle pulse on burst-length/rlast mismatch

Behaviour:
- Reset (asynchronous, rst_n=0): state=IDLE, beat cnt=0; req_ready_o, mem_rready_o, line_valid_o and proto_err_o are all 0; line_data_o=0.
- States are IDLE, COLLECT and OUTPUT.
- IDLE:
  - req_ready_o=1.
  - On req_valid_i: latch offset, clear the data register, cnt=0, go to COLLECT.
- COLLECT:
  - mem_rready_o=1; req_ready_o=0.
  - On each beat (rvalid&rready): write mem_rdata_i into word index (offset[5:3]+cnt) mod BEATS; cnt++.
  - Index arithmetic is 3-bit and wraps naturally.
- Burst end occurs on the beat where cnt==BEATS-1 or mem_rlast_i=1.
  - Go to OUTPUT on the next cycle.
  - If rlast is absent on beat 8, or present before beat 8: pulse proto_err_o for 1 cycle.
  - On a protocol error the line is still delivered; unwritten words stay 0.
  - Beats beyond 8 without rlast are not accepted: mem_rready_o=0 once in OUTPUT.
- OUTPUT:
  - line_valid_o=1; line_data_o is held stable until line_ready_i.
  - mem_rready_o=0.
  - Latency: line_valid_o asserts the cycle after the last beat handshake.
- OUTPUT exit (on line_ready_i):
  - If req_valid_i is high the same cycle: req_ready_o=1, latch the new offset, clear the data register, go directly to COLLECT (back-to-back, no idle bubble).
  - Otherwise go to IDLE.
- req_ready_o = (state==IDLE) | (state==OUTPUT & line_ready_i). This is combinational on line_ready_i only; there is no combinational path from mem_rvalid_i to any output.
- Reset asserted mid-burst discards partial data; beats arriving after reset release with no request are not accepted (mem_rready_o=0 in IDLE).
- Throughput: one beat per cycle while mem_rvalid_i is held; a full line costs 8 beat cycles + 1 output cycle, with back-to-back requests overlapped.

Decomposition:
- Shared cc package holds:
  - localparams BEAT_W, BEATS, OFF_W, LINE_W=518;
  - typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_OUTPUT};
  - function word_idx(offset, cnt) returning the 3-bit wrapped index.
- Single module. No sub-module; the 512-bit register with per-word write enables is inline.

Test Plan:
- Aligned fill: req offset=0x00, beats D0..D7 = 0x1000+i, rlast on beat 8 -> line_valid_o the next cycle, word k = 0x1000+k, offset field 0, proto_err_o=0.
- Wrapped fill: req offset=0x28 (word 5), beats 0xA0..0xA7 -> word5=0xA0, word6=0xA1, word7=0xA2, word0=0xA3, …, word4=0xA7; offset field 0x28.
- Backpressure plus gaps: mem_rvalid_i toggling 1/0 during collect, line_ready_i held low 5 cycles -> line_data_o stable throughout, mem_rready_o=0 during those 5 cycles; accepted on the 6th cycle.
- Back-to-back: second req (offset 0x10) valid while OUTPUT and line_ready_i=1 -> req_ready_o=1 that cycle, COLLECT the next cycle, second line correct, no dropped beat.
- Protocol error: rlast on beat 4 -> proto_err_o single pulse, line delivered with 4 words written and the rest 0; a separate case with no rlast on beat 8 -> pulse, and the 9th beat is not accepted.
- Reset mid-burst: rst_n low after beat 3 -> all outputs 0 immediately (asynchronous); after release, a fresh req at offset 0x38 yields a correct line with no residue from the aborted burst.

Source files
------------

// File: rtl/cc_line_deserializer_pkg.sv
// Shared definitions for the cache-controller line fill path.
// Covers the beat geometry, the deserializer state encoding and the wrapped word index helper.
package cc_line_deserializer_pkg;

  localparam int BEAT_W  = 64;
  localparam int BEATS   = 8;
  localparam int OFF_W   = 6;
  localparam int LINE_W  = BEAT_W * BEATS + OFF_W;
  localparam int CNT_W   = $clog2(BEATS);
  localparam int BYTE_SH = $clog2(BEAT_W / 8);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_OUTPUT  = 2'd2
  } state_e;

  // Word slot for the cnt-th beat of a critical-word-first burst; wraps modulo BEATS.
  function automatic logic [CNT_W-1:0] word_idx(input logic [OFF_W-1:0] offset,
                                                input logic [CNT_W-1:0] cnt);
    return offset[BYTE_SH +: CNT_W] + cnt;
  endfunction

endpackage

// File: rtl/cc_line_deserializer.sv
// Collects a wrapped 8-beat R burst into one naturally ordered line word with its byte offset.
// Delivers the line over valid/ready and flags burst-length/rlast disagreement.
module cc_line_deserializer
  import cc_line_deserializer_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid_i,
  input  logic [OFF_W-1:0]  req_offset_i,
  output logic              req_ready_o,
  input  logic [BEAT_W-1:0] mem_rdata_i,
  input  logic              mem_rlast_i,
  input  logic              mem_rvalid_i,
  output logic              mem_rready_o,
  output logic              line_valid_o,
  output logic [LINE_W-1:0] line_data_o,
  input  logic              line_ready_i,
  output logic              proto_err_o
);

  state_e                        state_r;
  logic [CNT_W-1:0]              cnt_r;
  logic [OFF_W-1:0]              off_r;
  logic [BEATS-1:0][BEAT_W-1:0]  data_r;
  logic                          mem_rready_r;
  logic                          line_valid_r;
  logic                          proto_err_r;

  logic                          beat_s;
  logic                          last_s;
  logic                          len_err_s;
  logic [CNT_W-1:0]              widx_s;
  logic [BEATS-1:0]              we_s;

  // Beat handshake, burst-end detection and per-word write enables
  always_comb begin
    beat_s    = mem_rvalid_i & mem_rready_r;
    widx_s    = word_idx(off_r, cnt_r);
    last_s    = (cnt_r == CNT_W'(BEATS - 1)) | mem_rlast_i;
    len_err_s = (cnt_r == CNT_W'(BEATS - 1)) ^ mem_rlast_i;
    for (int k = 0; k < BEATS; k++) begin
      we_s[k] = beat_s && (state_r == S_COLLECT) && (widx_s == CNT_W'(k));
    end
  end

  // Fill FSM with line assembly register and registered handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= S_IDLE;
      cnt_r        <= '0;
      off_r        <= '0;
      data_r       <= '0;
      mem_rready_r <= 1'b0;
      line_valid_r <= 1'b0;
      proto_err_r  <= 1'b0;
    end else begin
      proto_err_r <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (req_valid_i) begin
            off_r        <= req_offset_i;
            data_r       <= '0;
            cnt_r        <= '0;
            mem_rready_r <= 1'b1;
            state_r      <= S_COLLECT;
          end
        end
        S_COLLECT: begin
          for (int k = 0; k < BEATS; k++) begin
            if (we_s[k]) begin
              data_r[k] <= mem_rdata_i;
            end
          end
          if (beat_s) begin
            cnt_r <= cnt_r + CNT_W'(1);
            if (last_s) begin
              mem_rready_r <= 1'b0;
              line_valid_r <= 1'b1;
              proto_err_r  <= len_err_s;
              state_r      <= S_OUTPUT;
            end
          end
        end
        S_OUTPUT: begin
          if (line_ready_i) begin
            line_valid_r <= 1'b0;
            // A request in the same cycle restarts collection without an idle bubble
            if (req_valid_i) begin
              off_r        <= req_offset_i;
              data_r       <= '0;
              cnt_r        <= '0;
              mem_rready_r <= 1'b1;
              state_r      <= S_COLLECT;
            end else begin
              state_r <= S_IDLE;
            end
          end
        end
        default: begin
          state_r      <= S_IDLE;
          mem_rready_r <= 1'b0;
          line_valid_r <= 1'b0;
        end
      endcase
    end
  end

  // Request acceptance is held low while reset is asserted
  always_comb begin
    req_ready_o = rst_n & ((state_r == S_IDLE) | ((state_r == S_OUTPUT) & line_ready_i));
  end

  assign mem_rready_o = mem_rready_r;
  assign line_valid_o = line_valid_r;
  assign proto_err_o  = proto_err_r;
  assign line_data_o  = {off_r, data_r};

endmodule

// File: tb/tb_cc_line_deserializer.sv
// Randomized self-checking bench for cc_line_deserializer.
// Expected lines are built from the burst beats and start word using plain modulo arithmetic.
module tb_cc_line_deserializer;
  import cc_line_deserializer_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req_valid_i;
  logic [5:0]        req_offset_i;
  logic              req_ready_o;
  logic [63:0]       mem_rdata_i;
  logic              mem_rlast_i;
  logic              mem_rvalid_i;
  logic              mem_rready_o;
  logic              line_valid_o;
  logic [517:0]      line_data_o;
  logic              line_ready_i;
  logic              proto_err_o;

  int checks = 0;
  int errors = 0;

  cc_line_deserializer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid_i  (req_valid_i),
    .req_offset_i (req_offset_i),
    .req_ready_o  (req_ready_o),
    .mem_rdata_i  (mem_rdata_i),
    .mem_rlast_i  (mem_rlast_i),
    .mem_rvalid_i (mem_rvalid_i),
    .mem_rready_o (mem_rready_o),
    .line_valid_o (line_valid_o),
    .line_data_o  (line_data_o),
    .line_ready_i (line_ready_i),
    .proto_err_o  (proto_err_o)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 1ms");
    $fatal(1);
  end

  // One fill: request (unless already accepted back-to-back), beats, line checks, handoff.
  // rlast_pos is the 0-based beat carrying rlast, or -1 for none; extra presents a 9th beat.
  task automatic run_burst(input logic [5:0] off, input int rlast_pos, input bit extra,
                           input logic [63:0] base, input int gap, input int stall,
                           input bit skip_req, input bit b2b, input logic [5:0] next_off);
    logic [63:0]  beats [9];
    logic [511:0] exp_data;
    logic [517:0] exp_line;
    int exp_n, accepted, budget, start;
    bit exp_err, drv, rr;
    exp_n   = (rlast_pos >= 0 && rlast_pos < 7) ? rlast_pos + 1 : 8;
    exp_err = (rlast_pos != 7);
    start   = int'(off) / 8;
    for (int i = 0; i < 9; i++) beats[i] = (base != 64'd0) ? base + 64'(i) : {$urandom, $urandom};
    exp_data = '0;
    for (int i = 0; i < exp_n; i++) exp_data[64 * ((start + i) % 8) +: 64] = beats[i];
    exp_line = {off, exp_data};

    if (!skip_req) begin
      req_valid_i = 1'b1; req_offset_i = off; #1;
      checks++;
      if (req_ready_o !== 1'b1) begin
        errors++; $display("FAIL req_ready_idle: got %b expected 1", req_ready_o);
      end
      @(negedge clk);
      req_valid_i = 1'b0;
    end
    checks++;
    if (mem_rready_o !== 1'b1) begin
      errors++; $display("FAIL rready_collect: got %b expected 1", mem_rready_o);
    end

    accepted = 0; budget = 0;
    while (accepted < exp_n) begin
      if (budget > 200) begin
        checks++; errors++;
        $display("FAIL beat_timeout: got %0d beats accepted expected %0d", accepted, exp_n);
        mem_rvalid_i = 1'b0; req_valid_i = 1'b0; line_ready_i = 1'b0;
        return;
      end
      budget++;
      if (int'($urandom_range(99)) >= gap) begin
        mem_rvalid_i = 1'b1; mem_rdata_i = beats[accepted];
        mem_rlast_i = (accepted == rlast_pos); drv = 1'b1; rr = mem_rready_o;
      end else begin
        drv = 1'b0; rr = 1'b0;
      end
      @(negedge clk);
      if (drv && rr) accepted++;
      mem_rvalid_i = 1'b0; mem_rlast_i = 1'b0; mem_rdata_i = 64'd0;
    end

    checks++;
    if (line_valid_o !== 1'b1) begin
      errors++; $display("FAIL line_valid_latency: got %b expected 1", line_valid_o);
    end
    checks++;
    if (line_data_o !== exp_line) begin
      errors++; $display("FAIL line_data: got %h expected %h", line_data_o, exp_line);
    end
    checks++;
    if (proto_err_o !== exp_err) begin
      errors++; $display("FAIL proto_err: got %b expected %b", proto_err_o, exp_err);
    end
    checks++;
    if (mem_rready_o !== 1'b0) begin
      errors++; $display("FAIL rready_output: got %b expected 0", mem_rready_o);
    end

    if (extra) begin
      mem_rvalid_i = 1'b1; mem_rdata_i = beats[8]; mem_rlast_i = 1'b1;
    end
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      checks++;
      if (line_valid_o !== 1'b1 || line_data_o !== exp_line || mem_rready_o !== 1'b0 || proto_err_o !== 1'b0) begin
        errors++;
        $display("FAIL output_hold: got valid=%b rready=%b perr=%b data=%h expected valid=1 rready=0 perr=0 data=%h",
                 line_valid_o, mem_rready_o, proto_err_o, line_data_o, exp_line);
      end
    end
    mem_rvalid_i = 1'b0; mem_rlast_i = 1'b0;

    line_ready_i = 1'b1;
    if (b2b) begin
      req_valid_i = 1'b1; req_offset_i = next_off;
    end
    #1;
    checks++;
    if (req_ready_o !== 1'b1) begin
      errors++; $display("FAIL req_ready_output: got %b expected 1", req_ready_o);
    end
    @(negedge clk);
    line_ready_i = 1'b0; req_valid_i = 1'b0;
    checks++;
    if (line_valid_o !== 1'b0 || proto_err_o !== 1'b0 || mem_rready_o !== b2b) begin
      errors++;
      $display("FAIL handoff: got valid=%b perr=%b rready=%b expected valid=0 perr=0 rready=%b",
               line_valid_o, proto_err_o, mem_rready_o, b2b);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; req_valid_i = 1'b0; req_offset_i = 6'd0; mem_rdata_i = 64'd0;
    mem_rlast_i = 1'b0; mem_rvalid_i = 1'b0; line_ready_i = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (req_ready_o !== 1'b0 || mem_rready_o !== 1'b0 || line_valid_o !== 1'b0 || proto_err_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got req_ready=%b rready=%b valid=%b perr=%b expected all 0",
               req_ready_o, mem_rready_o, line_valid_o, proto_err_o);
    end
    checks++;
    if (line_data_o !== 518'd0) begin
      errors++; $display("FAIL reset_data: got %h expected 0", line_data_o);
    end
    rst_n = 1'b1; #1;
    checks++;
    if (req_ready_o !== 1'b1 || mem_rready_o !== 1'b0) begin
      errors++; $display("FAIL idle_after_reset: got req_ready=%b rready=%b expected 1 0", req_ready_o, mem_rready_o);
    end
    @(negedge clk);
  endtask

  task automatic test_aligned;
    run_burst(6'h00, 7, 1'b0, 64'h1000, 0, 0, 1'b0, 1'b0, 6'h00);
  endtask

  task automatic test_wrapped;
    run_burst(6'h28, 7, 1'b0, 64'hA0, 0, 1, 1'b0, 1'b0, 6'h00);
  endtask

  task automatic test_backpressure;
    run_burst(6'($urandom), 7, 1'b0, 64'd0, 50, 5, 1'b0, 1'b0, 6'h00);
  endtask

  task automatic test_back_to_back;
    run_burst(6'h20, 7, 1'b0, 64'd0, 0, 0, 1'b0, 1'b1, 6'h10);
    run_burst(6'h10, 7, 1'b0, 64'd0, 0, 1, 1'b1, 1'b0, 6'h00);
  endtask

  task automatic test_proto_err;
    run_burst(6'h18, 3, 1'b0, 64'd0, 0, 2, 1'b0, 1'b0, 6'h00);
    run_burst(6'h08, -1, 1'b1, 64'd0, 0, 3, 1'b0, 1'b0, 6'h00);
  endtask

  task automatic test_random;
    logic [5:0] cur_off, nxt_off;
    int r, pos;
    bit skip, b2b;
    cur_off = 6'($urandom); skip = 1'b0;
    for (int n = 0; n < 20; n++) begin
      r = int'($urandom_range(11));
      pos = (r == 11) ? -1 : ((r > 7) ? 7 : r);
      b2b = (n < 19) && ($urandom_range(1) == 1);
      nxt_off = 6'($urandom);
      run_burst(cur_off, pos, (pos < 0), 64'd0, int'($urandom_range(50)), int'($urandom_range(3)),
                skip, b2b, nxt_off);
      skip = b2b; cur_off = nxt_off;
    end
  endtask

  task automatic test_reset_mid_burst;
    req_valid_i = 1'b1; req_offset_i = 6'($urandom);
    @(negedge clk);
    req_valid_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      mem_rvalid_i = 1'b1; mem_rdata_i = {$urandom, $urandom}; mem_rlast_i = 1'b0;
      @(negedge clk);
    end
    mem_rvalid_i = 1'b0;
    rst_n = 1'b0; #1;
    checks++;
    if (req_ready_o !== 1'b0 || mem_rready_o !== 1'b0 || line_valid_o !== 1'b0 ||
        proto_err_o !== 1'b0 || line_data_o !== 518'd0) begin
      errors++;
      $display("FAIL async_reset: got req_ready=%b rready=%b valid=%b perr=%b data=%h expected all 0",
               req_ready_o, mem_rready_o, line_valid_o, proto_err_o, line_data_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      mem_rvalid_i = 1'b1; mem_rdata_i = {$urandom, $urandom};
      @(negedge clk);
      checks++;
      if (mem_rready_o !== 1'b0 || line_valid_o !== 1'b0) begin
        errors++; $display("FAIL idle_no_accept: got rready=%b valid=%b expected 0 0", mem_rready_o, line_valid_o);
      end
    end
    mem_rvalid_i = 1'b0;
    run_burst(6'h38, 7, 1'b0, 64'd0, 0, 1, 1'b0, 1'b0, 6'h00);
  endtask

  initial begin
    test_reset();
    test_aligned();
    test_wrapped();
    test_backpressure();
    test_back_to_back();
    test_proto_err();
    test_random();
    test_reset_mid_burst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
